// File: rtl/laser_dac_sequencer.sv
// Laser current loop controller: sends the DAC power-up commands, then turns each frame's
// minimum ADC sample into a clamped DAC code and streams it as a WRUP+LDAC pair.
`timescale 1ns/1ps
module laser_dac_sequencer #(
    parameter logic [15:0] DAC_INIT   = 16'd20000,
    parameter logic [11:0] SETPOINT   = 12'd3500,
    parameter logic [11:0] BAND_LO    = 12'd3300,
    parameter logic [11:0] BAND_HI    = 12'd3700,
    parameter logic [15:0] DAC_MIN    = 16'd0,
    parameter logic [15:0] DAC_MAX    = 16'd65490,
    parameter int unsigned GAIN_SHIFT = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        frame_valid,
    input  logic [11:0] min_adc_data,
    input  logic        spi_busy,
    output logic        spi_start,
    output logic [23:0] spi_data,
    output logic [15:0] dac_code,
    output logic        init_done,
    output logic        loop_locked,
    output logic        pending_ovf
);

    localparam logic [23:0] CMD_CLR  = 24'h010000;
    localparam logic [23:0] CMD_LDAC = 24'h180001;

    typedef enum logic [2:0] {
        INIT_CLR, INIT_WRUP, INIT_LDAC, IDLE, CALC, RUN_WRUP, RUN_LDAC
    } state_t;

    typedef enum logic [1:0] {
        PH_ISSUE, PH_SEND, PH_WAIT_HI, PH_WAIT_LO
    } phase_t;

    state_t        state, next_state, launch_state;
    phase_t        phase, next_phase;
    logic          launch;
    logic          pending, next_pending;
    logic [11:0]   sample, next_sample;
    logic          next_start;
    logic [23:0]   next_data;
    logic [15:0]   next_code;
    logic          next_init, next_locked, next_ovf;

    logic [11:0]        rev;
    logic               in_band;
    logic signed [13:0] err;
    logic signed [13:0] delta;
    logic signed [17:0] sum;
    logic [15:0]        clamped;

    assign rev     = 12'hFFF - sample;
    assign in_band = (rev >= BAND_LO) && (rev <= BAND_HI);
    assign err     = $signed({2'b00, SETPOINT}) - $signed({2'b00, rev});
    assign delta   = err >>> GAIN_SHIFT;
    assign sum     = $signed({2'b00, dac_code}) + $signed({{4{delta[13]}}, delta});

    always_comb begin
        if (sum < $signed({2'b00, DAC_MIN}))
            clamped = DAC_MIN;
        else if (sum > $signed({2'b00, DAC_MAX}))
            clamped = DAC_MAX;
        else
            clamped = sum[15:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= INIT_CLR;
            phase       <= PH_ISSUE;
            pending     <= 1'b0;
            sample      <= '0;
            spi_start   <= 1'b0;
            spi_data    <= '0;
            dac_code    <= DAC_INIT;
            init_done   <= 1'b0;
            loop_locked <= 1'b0;
            pending_ovf <= 1'b0;
        end else begin
            state       <= next_state;
            phase       <= next_phase;
            pending     <= next_pending;
            sample      <= next_sample;
            spi_start   <= next_start;
            spi_data    <= next_data;
            dac_code    <= next_code;
            init_done   <= next_init;
            loop_locked <= next_locked;
            pending_ovf <= next_ovf;
        end
    end

    always_comb begin
        next_state   = state;
        next_phase   = phase;
        next_start   = 1'b0;
        next_data    = spi_data;
        next_code    = dac_code;
        next_init    = init_done;
        next_locked  = loop_locked;
        next_ovf     = pending_ovf;
        next_pending = pending;
        next_sample  = sample;
        launch       = 1'b0;
        launch_state = state;

        // CALC consumes the pending sample; a frame in that same cycle re-arms it without overflow
        if (state == CALC)
            next_pending = 1'b0;
        if (frame_valid) begin
            next_sample  = min_adc_data;
            next_pending = 1'b1;
            if (pending && (state != CALC))
                next_ovf = 1'b1;
        end

        case (state)
            INIT_CLR, INIT_WRUP, INIT_LDAC, RUN_WRUP, RUN_LDAC: begin
                case (phase)
                    PH_ISSUE: begin
                        launch       = 1'b1;
                        launch_state = state;
                    end
                    PH_SEND:    next_phase = PH_WAIT_HI;
                    PH_WAIT_HI: if (spi_busy) next_phase = PH_WAIT_LO;
                    PH_WAIT_LO: begin
                        if (!spi_busy) begin
                            case (state)
                                INIT_CLR: begin
                                    launch       = 1'b1;
                                    launch_state = INIT_WRUP;
                                end
                                INIT_WRUP: begin
                                    launch       = 1'b1;
                                    launch_state = INIT_LDAC;
                                end
                                INIT_LDAC: begin
                                    next_state = IDLE;
                                    next_init  = 1'b1;
                                end
                                RUN_WRUP: begin
                                    launch       = 1'b1;
                                    launch_state = RUN_LDAC;
                                end
                                default: next_state = IDLE;
                            endcase
                        end
                    end
                    default: next_phase = PH_ISSUE;
                endcase
            end
            IDLE: begin
                // A frame arriving this cycle counts as pending so the WRUP start lands two cycles later
                if (enable && (pending || frame_valid))
                    next_state = CALC;
            end
            CALC: begin
                if (in_band) begin
                    next_locked = 1'b1;
                    next_state  = IDLE;
                end else begin
                    next_locked  = 1'b0;
                    next_code    = clamped;
                    launch       = 1'b1;
                    launch_state = RUN_WRUP;
                end
            end
            default: begin
                next_state = INIT_CLR;
                next_phase = PH_ISSUE;
            end
        endcase

        // Outputs are registered, so a launch loads start and data for the following cycle
        if (launch) begin
            next_state = launch_state;
            next_phase = PH_SEND;
            next_start = 1'b1;
            case (launch_state)
                INIT_CLR:            next_data = CMD_CLR;
                INIT_LDAC, RUN_LDAC: next_data = CMD_LDAC;
                default:             next_data = {8'h10, next_code};
            endcase
        end
    end

endmodule

// File: tb/tb_laser_dac_sequencer.sv
// Bench for laser_dac_sequencer: SPI busy responder, command-word monitor and an
// arithmetic model of the loop update, driven by directed and random frames.
`timescale 1ns/1ps
module tb_laser_dac_sequencer;

    localparam logic [23:0] CLR_W  = 24'h010000;
    localparam logic [23:0] LDAC_W = 24'h180001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        frame_valid = 1'b0;
    logic [11:0] min_adc_data = '0;
    logic        spi_busy;
    logic        spi_start;
    logic [23:0] spi_data;
    logic [15:0] dac_code;
    logic        init_done;
    logic        loop_locked;
    logic        pending_ovf;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_len = 30;
    int busy_cnt = 0;
    int first_start_cyc = -1;
    int frame_cyc = 0;
    int exp_code = 20000;
    bit exp_locked = 1'b0;
    logic [23:0] words[$];

    laser_dac_sequencer dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .frame_valid(frame_valid),
        .min_adc_data(min_adc_data), .spi_busy(spi_busy), .spi_start(spi_start),
        .spi_data(spi_data), .dac_code(dac_code), .init_done(init_done),
        .loop_locked(loop_locked), .pending_ovf(pending_ovf)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SPI master stand-in: busy from the cycle after start for busy_len cycles
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_busy <= 1'b0;
            busy_cnt <= 0;
        end else if (spi_start) begin
            spi_busy <= 1'b1;
            busy_cnt <= busy_len;
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else begin
            busy_cnt <= 0;
            spi_busy <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && spi_start) begin
            if (words.size() == 0) first_start_cyc = cyc;
            words.push_back(spi_data);
            checks++;
            if (spi_busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL start_while_busy busy=%b required 0", spi_busy);
            end
        end
    end

    initial begin
        #20_000_000;
        $display("[TB] FAIL global_timeout simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Loop law from first principles: integer floor division of the error by 2^7, then clamp
    task automatic model_frame(input int s, output bit upd);
        int rev, err, delta, sum;
        rev = 4095 - s;
        if (rev >= 3300 && rev <= 3700) begin
            exp_locked = 1'b1;
            upd = 1'b0;
        end else begin
            exp_locked = 1'b0;
            err = 3500 - rev;
            delta = (err >= 0) ? err / 128 : -((-err + 127) / 128);
            sum = exp_code + delta;
            if (sum < 0) sum = 0;
            if (sum > 65490) sum = 65490;
            exp_code = sum;
            upd = 1'b1;
        end
    endtask

    task automatic pulse_frame(input int s);
        frame_valid = 1'b1;
        min_adc_data = 12'(s);
        frame_cyc = cyc;
        tick();
        frame_valid = 1'b0;
    endtask

    task automatic wait_words(input int n, input int bound, input string tag);
        int k = 0;
        while (words.size() < n && k < bound) begin
            tick();
            k++;
        end
        if (words.size() < n) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout words=%0d required %0d", tag, words.size(), n);
        end
    endtask

    task automatic wait_quiet();
        int k = 0;
        tick();
        while (spi_busy && k < 200) begin
            tick();
            k++;
        end
        tick();
        tick();
    endtask

    task automatic wait_init();
        int k = 0;
        while (!init_done && k < 1000) begin
            tick();
            k++;
        end
        if (!init_done) begin
            checks++;
            errors++;
            $display("[TB] FAIL init_timeout init_done=%b required 1", init_done);
        end
        tick();
        tick();
    endtask

    task automatic check_pair(input string tag);
        checks++;
        if (words.size() !== 2) begin
            errors++;
            $display("[TB] FAIL %s_count words=%0d required 2", tag, words.size());
        end else begin
            checks += 2;
            if (words[0] !== {8'h10, 16'(exp_code)}) begin
                errors++;
                $display("[TB] FAIL %s_wrup got %h required %h", tag, words[0], {8'h10, 16'(exp_code)});
            end
            if (words[1] !== LDAC_W) begin
                errors++;
                $display("[TB] FAIL %s_ldac got %h required %h", tag, words[1], LDAC_W);
            end
        end
    endtask

    task automatic run_frame(input int s, input bit chk, input bit lat);
        bit upd;
        words.delete();
        model_frame(s, upd);
        pulse_frame(s);
        if (upd) begin
            wait_words(2, 400, "pair");
            wait_quiet();
        end else begin
            repeat (10) tick();
        end
        if (chk) begin
            if (upd) begin
                check_pair("frame");
            end else begin
                checks++;
                if (words.size() !== 0) begin
                    errors++;
                    $display("[TB] FAIL locked_traffic words=%0d required 0", words.size());
                end
            end
            checks += 2;
            if (dac_code !== 16'(exp_code)) begin
                errors++;
                $display("[TB] FAIL dac_code got %0d required %0d", dac_code, exp_code);
            end
            if (loop_locked !== exp_locked) begin
                errors++;
                $display("[TB] FAIL loop_locked got %b required %b", loop_locked, exp_locked);
            end
            if (lat && upd) begin
                checks++;
                if (first_start_cyc - frame_cyc !== 2) begin
                    errors++;
                    $display("[TB] FAIL latency got %0d required 2", first_start_cyc - frame_cyc);
                end
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        checks += 6;
        if (spi_start !== 1'b0)      begin errors++; $display("[TB] FAIL %s_start got %b required 0", tag, spi_start); end
        if (spi_data !== 24'h0)      begin errors++; $display("[TB] FAIL %s_data got %h required 000000", tag, spi_data); end
        if (dac_code !== 16'd20000)  begin errors++; $display("[TB] FAIL %s_code got %0d required 20000", tag, dac_code); end
        if (init_done !== 1'b0)      begin errors++; $display("[TB] FAIL %s_init got %b required 0", tag, init_done); end
        if (loop_locked !== 1'b0)    begin errors++; $display("[TB] FAIL %s_locked got %b required 0", tag, loop_locked); end
        if (pending_ovf !== 1'b0)    begin errors++; $display("[TB] FAIL %s_ovf got %b required 0", tag, pending_ovf); end
    endtask

    task automatic check_init_seq(input string tag);
        checks++;
        if (words.size() !== 3) begin
            errors++;
            $display("[TB] FAIL %s_count words=%0d required 3", tag, words.size());
        end else begin
            checks += 3;
            if (words[0] !== CLR_W)     begin errors++; $display("[TB] FAIL %s_clr got %h required %h", tag, words[0], CLR_W); end
            if (words[1] !== 24'h104E20) begin errors++; $display("[TB] FAIL %s_wrup got %h required 104e20", tag, words[1]); end
            if (words[2] !== LDAC_W)    begin errors++; $display("[TB] FAIL %s_ldac got %h required %h", tag, words[2], LDAC_W); end
        end
        checks += 2;
        if (init_done !== 1'b1)     begin errors++; $display("[TB] FAIL %s_done got %b required 1", tag, init_done); end
        if (dac_code !== 16'd20000) begin errors++; $display("[TB] FAIL %s_code got %0d required 20000", tag, dac_code); end
    endtask

    task automatic test_reset();
        busy_len = 30;
        rst_n = 1'b0;
        repeat (3) tick();
        check_reset_values("reset");
        words.delete();
        rst_n = 1'b1;
        wait_init();
        check_init_seq("init");
        exp_code = 20000;
        exp_locked = 1'b0;
    endtask

    task automatic test_lock();
        enable = 1'b1;
        run_frame(595, 1'b1, 1'b0);
        repeat (90) tick();
        checks++;
        if (words.size() !== 0) begin
            errors++;
            $display("[TB] FAIL lock_quiet words=%0d required 0", words.size());
        end
    endtask

    task automatic test_update();
        run_frame(1095, 1'b1, 1'b1);
        checks++;
        if (dac_code !== 16'd20003) begin
            errors++;
            $display("[TB] FAIL update_code got %0d required 20003", dac_code);
        end
    endtask

    task automatic test_random();
        int s;
        for (int i = 0; i < 30; i++) begin
            busy_len = $urandom_range(1, 5);
            if ($urandom_range(0, 1) == 0) s = $urandom_range(0, 4095);
            else s = $urandom_range(395, 795);
            run_frame(s, 1'b1, 1'b1);
        end
    endtask

    task automatic test_enable();
        bit upd;
        busy_len = 30;
        words.delete();
        model_frame(1095, upd);
        pulse_frame(1095);
        wait_words(1, 50, "en_wrup");
        tick();
        enable = 1'b0;
        wait_words(2, 200, "en_ldac");
        wait_quiet();
        check_pair("en_first");
        words.delete();
        model_frame(1095, upd);
        pulse_frame(1095);
        repeat (100) tick();
        checks++;
        if (words.size() !== 0) begin
            errors++;
            $display("[TB] FAIL parked_traffic words=%0d required 0", words.size());
        end
        enable = 1'b1;
        wait_words(2, 200, "en_resume");
        wait_quiet();
        check_pair("en_resume");
        checks++;
        if (dac_code !== 16'(exp_code)) begin
            errors++;
            $display("[TB] FAIL en_code got %0d required %0d", dac_code, exp_code);
        end
    endtask

    task automatic test_back_to_back();
        bit upd;
        busy_len = 30;
        words.delete();
        model_frame(1095, upd);
        pulse_frame(1095);
        wait_words(1, 50, "b2b_first");
        repeat (3) tick();
        pulse_frame(1095);
        repeat (3) tick();
        model_frame(0, upd);
        pulse_frame(0);
        wait_words(4, 400, "b2b_pairs");
        wait_quiet();
        repeat (20) tick();
        checks += 2;
        if (pending_ovf !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_ovf got %b required 1", pending_ovf);
        end
        if (words.size() !== 4) begin
            errors++;
            $display("[TB] FAIL b2b_count words=%0d required 4", words.size());
        end else begin
            checks += 2;
            if (words[2] !== {8'h10, 16'(exp_code)}) begin
                errors++;
                $display("[TB] FAIL b2b_wrup got %h required %h", words[2], {8'h10, 16'(exp_code)});
            end
            if (words[3] !== LDAC_W) begin
                errors++;
                $display("[TB] FAIL b2b_ldac got %h required %h", words[3], LDAC_W);
            end
        end
        checks++;
        if (dac_code !== 16'(exp_code)) begin
            errors++;
            $display("[TB] FAIL b2b_code got %0d required %0d", dac_code, exp_code);
        end
    endtask

    task automatic test_reset_mid();
        bit upd;
        busy_len = 30;
        words.delete();
        model_frame(1095, upd);
        pulse_frame(1095);
        wait_words(1, 50, "mid_wrup");
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_reset");
        tick();
        tick();
        words.delete();
        rst_n = 1'b1;
        wait_init();
        check_init_seq("reinit");
        exp_code = 20000;
        exp_locked = 1'b0;
    endtask

    task automatic test_clamp_low();
        busy_len = 1;
        run_frame(394, 1'b1, 1'b0);
        for (int i = 0; i < 3999; i++) run_frame(0, 1'b0, 1'b0);
        checks++;
        if (dac_code !== 16'd3) begin
            errors++;
            $display("[TB] FAIL low_pre got %0d required 3", dac_code);
        end
        run_frame(0, 1'b1, 1'b0);
        checks++;
        if (dac_code !== 16'd0) begin
            errors++;
            $display("[TB] FAIL low_clamp got %0d required 0", dac_code);
        end
    endtask

    task automatic test_clamp_high();
        busy_len = 1;
        rst_n = 1'b0;
        tick();
        tick();
        words.delete();
        rst_n = 1'b1;
        wait_init();
        exp_code = 20000;
        exp_locked = 1'b0;
        run_frame(2195, 1'b1, 1'b0);
        for (int i = 0; i < 1684; i++) run_frame(4095, 1'b0, 1'b0);
        checks++;
        if (dac_code !== 16'd65480) begin
            errors++;
            $display("[TB] FAIL high_pre got %0d required 65480", dac_code);
        end
        run_frame(4095, 1'b1, 1'b0);
        checks++;
        if (dac_code !== 16'd65490) begin
            errors++;
            $display("[TB] FAIL high_clamp got %0d required 65490", dac_code);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_update();
        test_random();
        test_enable();
        test_back_to_back();
        test_reset_mid();
        test_clamp_low();
        test_clamp_high();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
